// File: rtl/gbe_tx_overflow_guard.sv
// 10GbE TX guard: drops frames on afull/overflow, counts events for mux_gbe_over.
// Optional `GBE_GUARD_EOF_INSERT_EN: close a frame truncated by overflow with out_eof.
module gbe_tx_overflow_guard #(
    parameter int DATA_WIDTH = 64,
    parameter bit AFULL_DROP = 1'b1
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_eof,
    input  logic                  gbe_tx_afull,
    input  logic                  gbe_tx_overflow,
    input  logic                  sw_clr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_eof,
    output logic [31:0]           status_word
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FRAME = 2'b01,
        DROP  = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  w_pass;
    logic                  w_drop_inc;
    logic                  w_afull_blk;
    logic                  w_ovf_rise;
    logic                  w_clr_rise;
    logic                  r_ovf_d;
    logic                  r_clr_d;
    logic [15:0]           r_drop_cnt;
    logic [11:0]           r_ovf_cnt;
    logic                  r_sticky_afull;
    logic                  r_sticky_ovf;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_eof;
    logic [31:0]           r_status;

    assign w_afull_blk = AFULL_DROP && gbe_tx_afull;
    assign w_ovf_rise  = gbe_tx_overflow & ~r_ovf_d;
    assign w_clr_rise  = sw_clr & ~r_clr_d;

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Overflow in FRAME outranks in_valid: the current word is never passed.
    always_comb begin
        w_state_nxt = r_state;
        w_pass      = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_afull_blk) begin
                        if (in_eof) w_drop_inc = 1'b1;
                        else        w_state_nxt = DROP;
                    end else begin
                        w_pass = 1'b1;
                        if (!in_eof) w_state_nxt = FRAME;
                    end
                end
            end
            FRAME: begin
                if (gbe_tx_overflow) begin
                    if (in_valid && in_eof) begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end else if (in_valid) begin
                    w_pass = 1'b1;
                    if (in_eof) w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (in_valid && in_eof) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
`ifdef GBE_GUARD_EOF_INSERT_EN
            if (r_state == FRAME && gbe_tx_overflow) begin
                r_out_valid <= 1'b1;
                r_out_eof   <= 1'b1;
                if (in_valid) r_out_data <= in_data;
            end else
`endif
            if (w_pass) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
                r_out_eof   <= in_eof;
            end else begin
                r_out_valid <= 1'b0;
                r_out_eof   <= 1'b0;
            end
        end
    end

    // A clear coinciding with an event restarts counting from that event.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_ovf_d        <= 1'b0;
            r_clr_d        <= 1'b0;
            r_drop_cnt     <= '0;
            r_ovf_cnt      <= '0;
            r_sticky_afull <= 1'b0;
            r_sticky_ovf   <= 1'b0;
        end else begin
            r_ovf_d <= gbe_tx_overflow;
            r_clr_d <= sw_clr;
            if (w_clr_rise) begin
                r_drop_cnt     <= {15'd0, w_drop_inc};
                r_ovf_cnt      <= {11'd0, w_ovf_rise};
                r_sticky_afull <= gbe_tx_afull;
                r_sticky_ovf   <= gbe_tx_overflow;
            end else begin
                if (w_drop_inc && r_drop_cnt != 16'hFFFF)
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                if (w_ovf_rise && r_ovf_cnt != 12'hFFF)
                    r_ovf_cnt <= r_ovf_cnt + 12'd1;
                r_sticky_afull <= r_sticky_afull | gbe_tx_afull;
                r_sticky_ovf   <= r_sticky_ovf | gbe_tx_overflow;
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_status <= '0;
        end else begin
            r_status <= {r_drop_cnt, r_ovf_cnt, r_sticky_afull,
                         r_sticky_ovf, r_state};
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_eof     = r_out_eof;
    assign status_word = r_status;

endmodule
